// File: rtl/vram_slow_ctrl.sv
// -----------------------------------------------------------------------------
// vram_slow_ctrl
//
// Synchronous initiator for the 32Kx8 slow VRAM (120 ns asynchronous SRAM).
// Single-cycle read/write requests from the video-register side are turned
// into timed nCE/nOE/nWE/address/data sequences on the SRAM pins. An internal
// VRAM address register is post-incremented by a programmable modulo after
// every completed access.
// -----------------------------------------------------------------------------
module vram_slow_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int RD_WAIT  = 4,
    parameter int WE_SETUP = 1,
    parameter int WE_WIDTH = 2,
    parameter int WE_HOLD  = 1
) (
    input  logic              CLK_24M,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              RW,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              ADDR_LOAD,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [ADDR_W-1:0] MOD,
    output logic [DATA_W-1:0] D_OUT,
    output logic              ACK,
    output logic              BUSY,
    output logic [ADDR_W-1:0] CUR_ADDR,
    output logic [ADDR_W-1:0] RAM_ADDR,
    inout  wire  [DATA_W-1:0] RAM_DQ,
    output logic              RAM_nCE,
    output logic              RAM_nOE,
    output logic              RAM_nWE
);

    // Counter must hold (largest phase length - 1).
    localparam int MAX_A   = (RD_WAIT  > WE_SETUP) ? RD_WAIT  : WE_SETUP;
    localparam int MAX_B   = (WE_WIDTH > WE_HOLD)  ? WE_WIDTH : WE_HOLD;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    if (RD_WAIT < 1 || WE_SETUP < 1 || WE_WIDTH < 1 || WE_HOLD < 1) begin : g_param_check
        $error("vram_slow_ctrl: all timing parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SU,
        S_WR_PW,
        S_WR_HD,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   cur_addr_reg;
    logic [ADDR_W-1:0]   ram_addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   d_out_reg;
    logic                dq_oe_reg;
    logic                nce_reg;
    logic                noe_reg;
    logic                nwe_reg;
    logic                ack_reg;
    logic                busy_reg;
    // Set when the address register is reloaded mid-access: the reload
    // replaces that access's post-increment.
    logic                discard_reg;

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            cur_addr_reg <= '0;
            ram_addr_reg <= '0;
            wdata_reg    <= '0;
            d_out_reg    <= '0;
            dq_oe_reg    <= 1'b0;
            nce_reg      <= 1'b1;
            noe_reg      <= 1'b1;
            nwe_reg      <= 1'b1;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            discard_reg  <= 1'b0;
        end else begin
            ack_reg <= 1'b0;

            // Reload while an access is on the pins: the pins keep the
            // captured address, only the register moves.
            if (busy_reg && ADDR_LOAD) begin
                cur_addr_reg <= ADDR_IN;
                discard_reg  <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (REQ) begin
                        ram_addr_reg <= ADDR_LOAD ? ADDR_IN : cur_addr_reg;
                        wdata_reg    <= D_IN;
                        discard_reg  <= 1'b0;
                        busy_reg     <= 1'b1;
                        nce_reg      <= 1'b0;
                        if (ADDR_LOAD) begin
                            cur_addr_reg <= ADDR_IN;
                        end
                        if (RW) begin
                            state_reg <= S_RD;
                            noe_reg   <= 1'b0;
                            cnt_reg   <= CNT_W'(RD_WAIT - 1);
                        end else begin
                            state_reg <= S_WR_SU;
                            dq_oe_reg <= 1'b1;
                            cnt_reg   <= CNT_W'(WE_SETUP - 1);
                        end
                    end else if (ADDR_LOAD) begin
                        cur_addr_reg <= ADDR_IN;
                    end
                end

                S_RD: begin
                    if (cnt_reg == '0) begin
                        d_out_reg <= RAM_DQ;
                        state_reg <= S_DONE;
                        nce_reg   <= 1'b1;
                        noe_reg   <= 1'b1;
                        ack_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                S_WR_SU: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_WR_PW;
                        nwe_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(WE_WIDTH - 1);
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                S_WR_PW: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_WR_HD;
                        nwe_reg   <= 1'b1;
                        cnt_reg   <= CNT_W'(WE_HOLD - 1);
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                S_WR_HD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_DONE;
                        nce_reg   <= 1'b1;
                        dq_oe_reg <= 1'b0;
                        ack_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // A load in this cycle beats the post-increment.
                    state_reg <= S_IDLE;
                    cnt_reg   <= '0;
                    if (ADDR_LOAD) begin
                        cur_addr_reg <= ADDR_IN;
                    end else if (!discard_reg) begin
                        cur_addr_reg <= cur_addr_reg + MOD;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    nce_reg   <= 1'b1;
                    noe_reg   <= 1'b1;
                    nwe_reg   <= 1'b1;
                    dq_oe_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign RAM_DQ   = dq_oe_reg ? wdata_reg : {DATA_W{1'bz}};
    assign D_OUT    = d_out_reg;
    assign ACK      = ack_reg;
    assign BUSY     = busy_reg;
    assign CUR_ADDR = cur_addr_reg;
    assign RAM_ADDR = ram_addr_reg;
    assign RAM_nCE  = nce_reg;
    assign RAM_nOE  = noe_reg;
    assign RAM_nWE  = nwe_reg;

endmodule

// File: tb/tb_vram_slow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vram_slow_ctrl
//
// Directed bench for vram_slow_ctrl with an SRAM device model on the pins and
// a timeline-based reference model of the expected pin/register behaviour,
// compared every cycle, plus hand-computed literal checks per scenario.
// -----------------------------------------------------------------------------
module tb_vram_slow_ctrl;

    localparam int RD_WAIT  = 4;
    localparam int WE_SETUP = 1;
    localparam int WE_WIDTH = 2;
    localparam int WE_HOLD  = 1;

    logic        clk = 1'b0;
    logic        reset, req, rw, addr_load;
    logic [7:0]  d_in;
    logic [14:0] addr_in, mod;
    logic [7:0]  d_out;
    logic        ack, busy;
    logic [14:0] cur_addr, ram_addr;
    wire  [7:0]  ram_dq;
    logic        ram_nce, ram_noe, ram_nwe;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vram_slow_ctrl dut (
        .CLK_24M   (clk),
        .RESET     (reset),
        .REQ       (req),
        .RW        (rw),
        .D_IN      (d_in),
        .ADDR_LOAD (addr_load),
        .ADDR_IN   (addr_in),
        .MOD       (mod),
        .D_OUT     (d_out),
        .ACK       (ack),
        .BUSY      (busy),
        .CUR_ADDR  (cur_addr),
        .RAM_ADDR  (ram_addr),
        .RAM_DQ    (ram_dq),
        .RAM_nCE   (ram_nce),
        .RAM_nOE   (ram_noe),
        .RAM_nWE   (ram_nwe)
    );

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // SRAM device on the pins
    logic [7:0] sram [0:32767];
    assign ram_dq = (!ram_nce && !ram_noe) ? sram[ram_addr] : 8'bz;
    always @(posedge clk) begin
        if (!ram_nce && !ram_nwe) sram[ram_addr] <= ram_dq;
    end

    // Reference model state
    logic [7:0]  exp_mem [0:32767];
    bit          m_valid = 0, m_active = 0, m_rw = 0, m_discard = 0;
    int          m_start = 0, m_len = 0;
    logic [14:0] m_addr = '0, m_cur = '0;
    logic [7:0]  m_data = '0, m_dout = '0;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            sram[i]    = init_val(i);
            exp_mem[i] = init_val(i);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an access accepted at edge S occupies cycles S..S+L-1, cycle S+L
    // is the ACK cycle, and the address register settles at edge S+L+1.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_valid = 1; m_active = 0; m_cur = '0; m_addr = '0;
            m_dout = '0; m_discard = 0;
        end else if (m_valid) begin
            if (m_active && cyc == m_start + m_len + 1) begin
                if (addr_load) m_cur = addr_in;
                else if (!m_discard) m_cur = 15'((int'(m_cur) + int'(mod)) % 32768);
                m_active = 0;
            end else if (m_active) begin
                if (addr_load) begin m_cur = addr_in; m_discard = 1; end
                if (cyc == m_start + m_len) begin
                    if (m_rw) m_dout = exp_mem[m_addr];
                    else      exp_mem[m_addr] = m_data;
                end
            end else if (req) begin
                if (addr_load) m_cur = addr_in;
                m_addr = m_cur; m_rw = rw; m_data = d_in; m_start = cyc;
                m_len = rw ? RD_WAIT : (WE_SETUP + WE_WIDTH + WE_HOLD);
                m_active = 1; m_discard = 0;
            end else if (addr_load) begin
                m_cur = addr_in;
            end
        end
        #1;
        if (m_valid) begin
            bit acc, dn, wlo;
            int off;
            off = cyc - m_start;
            acc = m_active && cyc >= m_start && cyc < m_start + m_len;
            dn  = m_active && cyc == m_start + m_len;
            wlo = acc && !m_rw && off >= WE_SETUP && off < WE_SETUP + WE_WIDTH;
            check("nce",      int'(ram_nce),  int'(!acc));
            check("noe",      int'(ram_noe),  int'(!(acc && m_rw)));
            check("nwe",      int'(ram_nwe),  int'(!wlo));
            check("ack",      int'(ack),      int'(dn));
            check("busy",     int'(busy),     int'(acc));
            check("cur_addr", int'(cur_addr), int'(m_cur));
            check("ram_addr", int'(ram_addr), int'(m_addr));
            check("d_out",    int'(d_out),    int'(m_dout));
            check("oe_we_overlap", int'(!ram_noe && !ram_nwe), 0);
            if (acc && !m_rw) check("dq_write", int'(ram_dq), int'(m_data));
            if (ack) $display("txn cyc=%0d %s addr=0x%04h d_out=0x%02h cur=0x%04h",
                              cyc, m_rw ? "RD" : "WR", ram_addr, d_out, cur_addr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Walks cycles until ACK (bounded); counts nWE-low cycles on the way.
    task automatic wait_ack(output int t, output int nwe_lo);
        t = -1;
        nwe_lo = 0;
        for (int k = 0; k < 20; k++) begin
            if (!ram_nwe) begin
                nwe_lo++;
                check("nwe_inside_nce", int'(ram_nce), 0);
            end
            if (ack) begin
                t = cyc;
                break;
            end
            tick();
        end
        n_cmp++;
        if (t < 0) begin
            n_bad++;
            $display("FAIL ack_timeout: got no ACK, expected ACK within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_req, t_ack, nwe_lo, last_ack, n_ack, hi_run;
        bit seen_low;

        // Reset held 3 cycles with REQ high
        reset = 1; req = 1; rw = 0; d_in = 8'h11; addr_load = 0; addr_in = '0; mod = '0;
        repeat (3) tick();
        check("rst_nce",  int'(ram_nce), 1);
        check("rst_noe",  int'(ram_noe), 1);
        check("rst_nwe",  int'(ram_nwe), 1);
        check("rst_ack",  int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cur",  int'(cur_addr), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_dout", int'(d_out), 0);
        reset = 0; req = 0;
        tick();

        // Write 0xA5 at 0x1234, MOD = 1
        addr_load = 1; addr_in = 15'h1234; mod = 15'h0001; req = 1; rw = 0; d_in = 8'hA5;
        t_req = cyc;
        tick();
        addr_load = 0; req = 0;
        wait_ack(t_ack, nwe_lo);
        check("wr_ack_latency", t_ack - t_req, 5);
        check("wr_nwe_width", nwe_lo, 2);
        tick();

        // Read at the incremented address 0x1235
        req = 1; rw = 1; t_req = cyc;
        tick();
        req = 0;
        wait_ack(t_ack, nwe_lo);
        check("rd_ack_latency", t_ack - t_req, 5);
        check("rd_1235_addr", int'(ram_addr), 'h1235);
        check("rd_1235_data", int'(d_out), int'(init_val('h1235)));
        tick();

        // Reload 0x1234 and read back
        addr_load = 1; addr_in = 15'h1234; req = 1; rw = 1;
        tick();
        addr_load = 0; req = 0;
        wait_ack(t_ack, nwe_lo);
        check("rd_1234_data", int'(d_out), 'hA5);
        tick();
        check("rd_1234_cur", int'(cur_addr), 'h1235);

        // Wrap-around: 0x7FFF + 2 -> 0x0001
        addr_load = 1; addr_in = 15'h7FFF; mod = 15'h0002; req = 1; rw = 0; d_in = 8'h5A;
        tick();
        addr_load = 0; req = 0;
        wait_ack(t_ack, nwe_lo);
        tick();
        check("wrap_cur", int'(cur_addr), 'h0001);

        // Back-to-back reads with REQ held 20 cycles
        mod = 15'h0001; rw = 1; req = 1;
        last_ack = -1; n_ack = 0; hi_run = 0; seen_low = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 20) req = 0;
            if (ack) begin
                if (last_ack >= 0) check("b2b_ack_spacing", cyc - last_ack, 6);
                last_ack = cyc;
                n_ack++;
            end
            if (ram_nce) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0) check("b2b_nce_gap", hi_run, 2);
                seen_low = 1;
                hi_run = 0;
            end
            tick();
        end
        check("b2b_ack_count", n_ack, 4);

        // ADDR_LOAD while busy: read at 0x0050, load 0x0100 mid-access
        addr_load = 1; addr_in = 15'h0050; req = 1; rw = 1;
        tick();
        req = 0; addr_load = 1; addr_in = 15'h0100;
        tick();
        addr_load = 0;
        wait_ack(t_ack, nwe_lo);
        check("ldbusy_ram_addr", int'(ram_addr), 'h0050);
        check("ldbusy_dout", int'(d_out), int'(init_val('h0050)));
        tick();
        check("ldbusy_cur", int'(cur_addr), 'h0100);

        // ADDR_LOAD coincident with DONE beats the increment
        req = 1; rw = 1;
        tick();
        req = 0;
        wait_ack(t_ack, nwe_lo);
        addr_load = 1; addr_in = 15'h0300;
        tick();
        addr_load = 0;
        check("lddone_cur", int'(cur_addr), 'h0300);

        // Reset in the second nWE-low cycle of a write
        addr_load = 1; addr_in = 15'h0200; req = 1; rw = 0; d_in = 8'h77;
        tick();
        addr_load = 0; req = 0;
        tick();
        tick();
        check("rstw_pw2_nwe", int'(ram_nwe), 0);
        reset = 1;
        tick();
        check("rstw_nwe",  int'(ram_nwe), 1);
        check("rstw_nce",  int'(ram_nce), 1);
        check("rstw_noe",  int'(ram_noe), 1);
        check("rstw_ack",  int'(ack), 0);
        check("rstw_busy", int'(busy), 0);
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rstw_no_ack", int'(ack), 0);
        end

        // Controller accepts immediately after reset and memory is intact
        addr_load = 1; addr_in = 15'h1234; req = 1; rw = 1; t_req = cyc;
        tick();
        addr_load = 0; req = 0;
        wait_ack(t_ack, nwe_lo);
        check("post_rst_latency", t_ack - t_req, 5);
        check("post_rst_data", int'(d_out), 'hA5);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
